pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It compares the ID-stage source registers against in-flight EXE/MEM destinations, reacts to taken branches resolved in EXE, and holds the whole pipe while the MEM stage waits on the data-memory controller. Its outputs drive the PC register and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline-register enables and flushes. There is no forwarding path in this design, so every RAW hazard stalls.

## Interface
- MEM_TIMEOUT, 64: consecutive not-ready MEM cycles before the pipe halts; 2..1023.
- clk  in  1  pipeline clock
- rst  in  1  reset, synchronous, active-high; sole clock domain `clk`
- id_valid  in  1  ID stage holds a real instruction
- id_src1, id_src2  in  5  ID source register numbers
- id_two_src  in  1  id_src2 is actually read (R-type, store, BNE)
- exe_dest, mem_dest  in  5  destination register numbers in EXE and MEM
- exe_wb_en, mem_wb_en  in  1  write-back enables in EXE and MEM
- br_taken  in  1  branch decision from EXE condition check
- mem_req  in  1  MEM stage performs a load or store (MEM_Signal != 0)
- mem_ready  in  1  data-memory controller completes this cycle
- pc_freeze  out  1  hold the PC
- ifid_freeze  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idexe_flush  out  1  insert a bubble into ID/EXE
- pipe_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
- States: RUN, MEM_WAIT, HALT. Reset state is RUN.
- mem_stall = mem_req & ~mem_ready.
- RUN:
  - If mem_stall, go to MEM_WAIT with wait_cnt = 1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - mem_ready or ~mem_req: go to RUN and clear wait_cnt.
  - Otherwise wait_cnt increments.
  - When wait_cnt == MEM_TIMEOUT and mem_stall is still true: go to HALT and set mem_err.
- HALT: absorbing; only rst exits it.
- RAW hazard: id_valid & wb_en & dest != 0 & (dest == id_src1 | (id_two_src & dest == id_src2)). Evaluated against the EXE pair and the MEM pair. R0 never hazards.
- Output priority, highest first:
  1. HALT: pc_freeze = ifid_freeze = pipe_freeze = 1; flushes 0.
  2. mem_stall, in any non-HALT state: pc_freeze = ifid_freeze = pipe_freeze = 1; flushes 0. A pending branch or hazard is held frozen and acted on after release.
  3. br_taken: ifid_flush = idexe_flush = 1; pc_freeze = 0, so the PC loads the branch target.
  4. hazard: pc_freeze = ifid_freeze = 1, idexe_flush = 1.
  5. Otherwise all 0.
- A branch takes priority over a simultaneous hazard. The hazarding instruction sits on the wrong path and is flushed.

## Timing
- Control outputs are combinational (Mealy) from the current inputs plus the registered state, and are valid in the same cycle.
- State, wait_cnt, mem_err and the counters update on posedge clk.
- While rst = 1, every freeze/flush output is 0. On the first edge with rst high: state = RUN, wait_cnt = 0, mem_err = 0, counters = 0.
- Reset asserted mid-wait or in HALT aborts cleanly to RUN on the next edge.
- Branch penalty is 2 bubbles. An EXE-only hazard stalls 2 cycles; a MEM-only hazard stalls 1 cycle.
- mem_ready arriving in the same cycle as mem_req gives zero stall cycles.
- Timeout: with MEM_TIMEOUT = N, the pipe is frozen for N cycles, HALT is entered on the N-th edge, and mem_err reads 1 from that edge on.

## Configuration
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_freeze = 1.
  - flush_cnt increments on every cycle with ifid_flush = 1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
- Undefined: the counter logic is absent, both ports are still present and tied to 0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - state enum (RUN, MEM_WAIT, HALT);
  - REG_ZERO = 5'd0;
  - MEM_Signal bit positions;
  - BR_TYPE encodings used to derive id_two_src.
- Sub-module `hazard_detect`: purely combinational RAW compare of one (dest, wb_en) pair against the ID sources; instantiated twice, once for EXE and once for MEM.

## Test plan
- Load-use: EXE holds dest = 5, wb_en = 1; ID reads id_src1 = 5 -> pc_freeze, ifid_freeze and idexe_flush are 1 for 2 cycles, then 0.
- R0 and single source: exe_dest = 0, or a match on id_src2 with id_two_src = 0 -> no stall.
- Branch plus hazard in the same cycle: br_taken = 1 and the hazard true -> ifid_flush = idexe_flush = 1, pc_freeze = 0; flush_cnt = 1 (PERF on).
- Memory wait: mem_req = 1 with mem_ready low for 3 cycles, br_taken = 1 throughout -> pipe_freeze = 1 for 3 cycles with no flush, then the flush fires in cycle 4; stall_cnt = 3.
- Timeout: MEM_TIMEOUT = 4, mem_ready held low -> HALT and mem_err = 1 after 4 cycles; raising mem_ready afterwards is ignored.
- Reset mid-wait: rst pulsed during MEM_WAIT -> next cycle state RUN, all outputs 0, counters 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // MEM_Signal bit positions; any set bit means the MEM stage touches memory.
    localparam int MEM_SIG_LOAD_BIT  = 0;
    localparam int MEM_SIG_STORE_BIT = 1;
    localparam int MEM_SIG_W         = 2;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEZ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_JMP  = 2'd3
    } br_type_e;

    function automatic logic mem_req_of(input logic [MEM_SIG_W-1:0] sig);
        return sig[MEM_SIG_LOAD_BIT] | sig[MEM_SIG_STORE_BIT];
    endfunction

    // BNE compares two registers, BEZ only one; stores read the data register.
    function automatic logic two_src_of(input logic is_rtype, input logic is_store,
                                        input br_type_e br);
        return is_rtype | is_store | (br == BR_BNE);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// RAW compare of one in-flight (dest, wb_en) pair against the ID-stage sources.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_src1,
    input  logic [4:0] id_src2,
    input  logic       id_two_src,
    input  logic [4:0] dest,
    input  logic       wb_en,
    output logic       hazard
);

    always_comb begin
        hazard = id_valid & wb_en & (dest != REG_ZERO) &
                 ((dest == id_src1) | (id_two_src & (dest == id_src2)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe (no forwarding: every RAW hazard stalls).
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic [4:0]  exe_dest,
    input  logic [4:0]  mem_dest,
    input  logic        exe_wb_en,
    input  logic        mem_wb_en,
    input  logic        br_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_freeze,
    output logic        ifid_freeze,
    output logic        ifid_flush,
    output logic        idexe_flush,
    output logic        pipe_freeze,
    output logic        mem_err,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d, wait_inc;
    logic            mem_err_q, mem_err_d;
    logic            mem_stall, hz_exe, hz_mem;

    hazard_detect u_hz_exe (
        .id_valid   (id_valid),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .dest       (exe_dest),
        .wb_en      (exe_wb_en),
        .hazard     (hz_exe)
    );

    hazard_detect u_hz_mem (
        .id_valid   (id_valid),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .dest       (mem_dest),
        .wb_en      (mem_wb_en),
        .hazard     (hz_mem)
    );

    assign mem_stall = mem_req & ~mem_ready;
    assign wait_inc  = wait_cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                    // The edge that completes the N-th frozen cycle enters HALT.
                    if (wait_inc == CW'(MEM_TIMEOUT)) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    // A frozen pipe keeps any pending branch/hazard in place until release.
    always_comb begin
        pc_freeze   = 1'b0;
        ifid_freeze = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            if (state_q == ST_HALT || mem_stall) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                pipe_freeze = 1'b1;
            end else if (br_taken) begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
            end else if (hz_exe || hz_mem) begin
                pc_freeze   = 1'b1;
                ifid_freeze = 1'b1;
                idexe_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_freeze && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (ifid_flush && flush_cnt_q != 32'hFFFF_FFFF)
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// checked against a streak-counting behavioural model.
module tb_pipe_ctrl;

    localparam int TMO = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id_valid, id_two_src, exe_wb_en, mem_wb_en, br_taken, mem_req, mem_ready;
    logic [4:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        pc_freeze, ifid_freeze, ifid_flush, idexe_flush, pipe_freeze, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .mem_dest(mem_dest),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze),
        .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
        .pipe_freeze(pipe_freeze), .mem_err(mem_err), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    wire [4:0] act_vec = {pc_freeze, ifid_freeze, ifid_flush, idexe_flush, pipe_freeze};

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a halted flag and the length of the current not-ready streak.
    bit              m_halt, m_err;
    int              m_streak;
    longint unsigned m_stall, m_flush;
    logic [4:0]      e_vec;

    function automatic void model_eval();
        bit hz_e, hz_m;
        hz_e = id_valid && exe_wb_en && exe_dest != 0 &&
               (exe_dest == id_src1 || (id_two_src && exe_dest == id_src2));
        hz_m = id_valid && mem_wb_en && mem_dest != 0 &&
               (mem_dest == id_src1 || (id_two_src && mem_dest == id_src2));
        if (rst)                                  e_vec = 5'b00000;
        else if (m_halt || (mem_req && !mem_ready)) e_vec = 5'b11001;
        else if (br_taken)                        e_vec = 5'b00110;
        else if (hz_e || hz_m)                    e_vec = 5'b11010;
        else                                      e_vec = 5'b00000;
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_halt = 0; m_err = 0; m_streak = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_vec[4] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_vec[2] && m_flush < 64'hFFFF_FFFF) m_flush++;
            if (!m_halt) begin
                if (mem_req && !mem_ready) m_streak++;
                else m_streak = 0;
                if (m_streak == TMO) begin
                    m_halt = 1; m_err = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
        exe_dest = 0; mem_dest = 0; exe_wb_en = 0; mem_wb_en = 0;
        br_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; br_taken = 1; mem_req = 1; id_valid = 1; id_src1 = 3;
        exe_dest = 3; exe_wb_en = 1;
        @(negedge clk); model_eval();
        n_cmp++;
        if (act_vec !== 5'b00000) begin
            n_bad++; $display("FAIL reset_outputs: got %b want 00000", act_vec);
        end
        tick(); idle();
        @(negedge clk); model_eval();
        n_cmp++;
        if (act_vec !== 5'b00000 || mem_err !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_state: vec %b err %b want 00000 0", act_vec, mem_err);
        end
        n_cmp++;
        if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            n_bad++; $display("FAIL post_reset_cnt: stall %0d flush %0d want 0 0", stall_cnt, flush_cnt);
        end
        tick();
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 3; c++) begin
            idle(); id_valid = 1; id_src1 = 5; id_src2 = 9; id_two_src = 1;
            if (c == 0) begin exe_dest = 5; exe_wb_en = 1; end
            if (c == 1) begin mem_dest = 5; mem_wb_en = 1; end
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== e_vec || act_vec !== ((c < 2) ? 5'b11010 : 5'b00000)) begin
                n_bad++; $display("FAIL load_use c%0d: got %b want %b", c, act_vec, e_vec);
            end
            tick();
        end
    endtask

    task automatic test_r0_single();
        for (int c = 0; c < 6; c++) begin
            idle(); id_valid = 1; exe_wb_en = 1; id_src1 = 1;
            case (c)
                0: begin exe_dest = 0; id_src1 = 0; end
                1: begin exe_dest = 7; id_src2 = 7; id_two_src = 0; end
                2: begin exe_wb_en = 0; mem_wb_en = 1; mem_dest = 0; id_src1 = 0;
                         id_src2 = 0; id_two_src = 1; end
                3: begin exe_dest = 7; id_src2 = 7; id_two_src = 1; end
                4: begin exe_dest = 1; id_valid = 0; end
                default: begin exe_dest = 1; exe_wb_en = 0; end
            endcase
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== e_vec) begin
                n_bad++; $display("FAIL r0_single c%0d: got %b want %b", c, act_vec, e_vec);
            end
            tick();
        end
    endtask

    task automatic test_branch_hazard();
        do_reset();
        id_valid = 1; id_src1 = 4; exe_dest = 4; exe_wb_en = 1; br_taken = 1;
        @(negedge clk); model_eval();
        n_cmp++;
        if (act_vec !== e_vec || act_vec !== 5'b00110) begin
            n_bad++; $display("FAIL branch_hazard: got %b want %b", act_vec, e_vec);
        end
        tick(); idle();
        @(negedge clk);
        n_cmp++;
        if (flush_cnt !== (PERF ? 32'(m_flush) : 32'd0)) begin
            n_bad++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt, PERF ? m_flush : 0);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle(); mem_req = 1; mem_ready = (c == 3); br_taken = 1;
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== e_vec || act_vec !== ((c < 3) ? 5'b11001 : 5'b00110)) begin
                n_bad++; $display("FAIL mem_wait c%0d: got %b want %b", c, act_vec, e_vec);
            end
            tick();
        end
        idle();
        @(negedge clk);
        n_cmp++;
        if (stall_cnt !== (PERF ? 32'd3 : 32'd0) || mem_err !== 1'b0) begin
            n_bad++; $display("FAIL mem_wait_cnt: stall %0d err %b want %0d 0",
                              stall_cnt, mem_err, PERF ? 3 : 0);
        end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < TMO + 3; c++) begin
            idle(); mem_req = 1; mem_ready = (c >= TMO); br_taken = (c >= TMO);
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== e_vec || mem_err !== m_err || mem_err !== (c >= TMO)) begin
                n_bad++; $display("FAIL timeout c%0d: vec %b err %b want %b %b",
                                  c, act_vec, mem_err, e_vec, m_err);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        // k=0: reset out of HALT left by the timeout test; k=1: reset mid-wait
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                do_reset();
                idle(); mem_req = 1; tick(); tick();
            end
            idle(); rst = 1; mem_req = 1; br_taken = 1;
            @(negedge clk);
            n_cmp++;
            if (act_vec !== 5'b00000) begin
                n_bad++; $display("FAIL reset_mid k%0d during: got %b want 00000", k, act_vec);
            end
            tick(); idle();
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== 5'b00000 || mem_err !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
                n_bad++; $display("FAIL reset_mid k%0d after: vec %b err %b stall %0d flush %0d want all 0",
                                  k, act_vec, mem_err, stall_cnt, flush_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 39) == 0);
            id_valid   = $urandom_range(0, 3) != 0;
            id_src1    = 5'($urandom_range(0, 3));
            id_src2    = 5'($urandom_range(0, 3));
            id_two_src = $urandom_range(0, 1) != 0;
            exe_dest   = 5'($urandom_range(0, 3));
            mem_dest   = 5'($urandom_range(0, 3));
            exe_wb_en  = $urandom_range(0, 1) != 0;
            mem_wb_en  = $urandom_range(0, 1) != 0;
            br_taken   = $urandom_range(0, 3) == 0;
            mem_req    = $urandom_range(0, 1) != 0;
            mem_ready  = $urandom_range(0, 9) < 3;
            @(negedge clk); model_eval();
            n_cmp++;
            if (act_vec !== e_vec) begin
                n_bad++; $display("FAIL rand_vec c%0d: got %b want %b", c, act_vec, e_vec);
            end
            n_cmp++;
            if (mem_err !== m_err) begin
                n_bad++; $display("FAIL rand_err c%0d: got %b want %b", c, mem_err, m_err);
            end
            n_cmp++;
            if (stall_cnt !== (PERF ? 32'(m_stall) : 32'd0) ||
                flush_cnt !== (PERF ? 32'(m_flush) : 32'd0)) begin
                n_bad++; $display("FAIL rand_cnt c%0d: stall %0d flush %0d want %0d %0d", c,
                                  stall_cnt, flush_cnt, PERF ? m_stall : 0, PERF ? m_flush : 0);
            end
            tick();
        end
    endtask

    initial begin
        m_halt = 0; m_err = 0; m_streak = 0; m_stall = 0; m_flush = 0; e_vec = 0;
        idle();
        test_reset();
        test_load_use();
        test_r0_single();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
